// File: rtl/sha_nonce_block_feeder.sv
// Padded second-chunk SHA-256 block generator for one mining core.
// Emits one 16-word block per nonce. Nonces are interleaved across NUMPROCESSORS cores.
// Jobs are queued through a one-entry pending slot so they can run back to back.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   job_valid_i/ready_o job handshake; job_w1/w2/w3_i, job_nonce_base_i, job_nonce_count_i
//   abort_i             drop the current and pending jobs
//   out_valid_o/ready_i block handshake; out_block_o ([15] first-used), out_nonce_o
//   out_newblock_o      first block of a job
//   out_last_o          last block of a job
//   busy_o              a current or pending job is held
module sha_nonce_block_feeder #(
  parameter int unsigned PROCESSORINDEX = 0,
  parameter int unsigned NUMPROCESSORS  = 1,
  parameter int unsigned MSG_LEN_BITS   = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [31:0]       job_w1_i,
  input  logic [31:0]       job_w2_i,
  input  logic [31:0]       job_w3_i,
  input  logic [31:0]       job_nonce_base_i,
  input  logic [31:0]       job_nonce_count_i,
  input  logic              abort_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [15:0][31:0] out_block_o,
  output logic [31:0]       out_nonce_o,
  output logic              out_newblock_o,
  output logic              out_last_o,
  output logic              busy_o
);

  localparam logic [0:0]  StIdle = 1'b0;
  localparam logic [0:0]  StRun  = 1'b1;
  localparam logic [31:0] Stride = 32'(NUMPROCESSORS);
  localparam logic [31:0] Offset = 32'(PROCESSORINDEX);
  localparam logic [31:0] MsgLen = 32'(MSG_LEN_BITS);

  logic [0:0]  state_q, state_d;
  logic [31:0] cur_w1_q, cur_w1_d, cur_w2_q, cur_w2_d, cur_w3_q, cur_w3_d;
  logic [31:0] cur_nonce_q, cur_nonce_d, cur_rem_q, cur_rem_d;
  logic        cur_first_q, cur_first_d, cur_last_q, cur_last_d;
  logic [31:0] pend_w1_q, pend_w1_d, pend_w2_q, pend_w2_d, pend_w3_q, pend_w3_d;
  logic [31:0] pend_nonce_q, pend_nonce_d, pend_count_q, pend_count_d;
  logic        pend_valid_q, pend_valid_d;

  logic accept, hs, load;

  assign job_ready_o = !pend_valid_q && !rst;
  assign accept      = job_valid_i && job_ready_o;
  assign hs          = (state_q == StRun) && out_ready_i;
  // The pending job moves up when idle, or on the last beat so no bubble appears.
  assign load        = pend_valid_q && ((state_q == StIdle) || (hs && cur_last_q));

  always_comb begin
    state_d      = state_q;
    cur_w1_d     = cur_w1_q;
    cur_w2_d     = cur_w2_q;
    cur_w3_d     = cur_w3_q;
    cur_nonce_d  = cur_nonce_q;
    cur_rem_d    = cur_rem_q;
    cur_first_d  = cur_first_q;
    cur_last_d   = cur_last_q;
    pend_w1_d    = pend_w1_q;
    pend_w2_d    = pend_w2_q;
    pend_w3_d    = pend_w3_q;
    pend_nonce_d = pend_nonce_q;
    pend_count_d = pend_count_q;
    pend_valid_d = pend_valid_q;

    if (abort_i) begin
      // Abort overrides any handshake or job acceptance in the same cycle.
      state_d      = StIdle;
      pend_valid_d = 1'b0;
      cur_first_d  = 1'b0;
      cur_last_d   = 1'b0;
    end else begin
      if (load) begin
        state_d      = StRun;
        cur_w1_d     = pend_w1_q;
        cur_w2_d     = pend_w2_q;
        cur_w3_d     = pend_w3_q;
        cur_nonce_d  = pend_nonce_q;
        cur_rem_d    = pend_count_q;
        cur_first_d  = 1'b1;
        cur_last_d   = (pend_count_q == 32'd1);
        pend_valid_d = 1'b0;
      end else if (hs && cur_last_q) begin
        state_d     = StIdle;
        cur_first_d = 1'b0;
        cur_last_d  = 1'b0;
      end else if (hs) begin
        cur_nonce_d = cur_nonce_q + Stride;
        cur_rem_d   = cur_rem_q - 32'd1;
        cur_first_d = 1'b0;
        cur_last_d  = (cur_rem_q == 32'd2);
      end

      // Zero-count jobs are accepted but never occupy the slot.
      if (accept && (job_nonce_count_i != 32'd0)) begin
        pend_w1_d    = job_w1_i;
        pend_w2_d    = job_w2_i;
        pend_w3_d    = job_w3_i;
        pend_nonce_d = job_nonce_base_i + Offset;
        pend_count_d = job_nonce_count_i;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cur_w1_q     <= '0;
      cur_w2_q     <= '0;
      cur_w3_q     <= '0;
      cur_nonce_q  <= '0;
      cur_rem_q    <= '0;
      cur_first_q  <= 1'b0;
      cur_last_q   <= 1'b0;
      pend_w1_q    <= '0;
      pend_w2_q    <= '0;
      pend_w3_q    <= '0;
      pend_nonce_q <= '0;
      pend_count_q <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_w1_q     <= cur_w1_d;
      cur_w2_q     <= cur_w2_d;
      cur_w3_q     <= cur_w3_d;
      cur_nonce_q  <= cur_nonce_d;
      cur_rem_q    <= cur_rem_d;
      cur_first_q  <= cur_first_d;
      cur_last_q   <= cur_last_d;
      pend_w1_q    <= pend_w1_d;
      pend_w2_q    <= pend_w2_d;
      pend_w3_q    <= pend_w3_d;
      pend_nonce_q <= pend_nonce_d;
      pend_count_q <= pend_count_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  always_comb begin
    out_block_o     = '0;
    out_block_o[15] = cur_w1_q;
    out_block_o[14] = cur_w2_q;
    out_block_o[13] = cur_w3_q;
    out_block_o[12] = cur_nonce_q;
    out_block_o[11] = 32'h8000_0000;
    out_block_o[0]  = MsgLen;
  end

  assign out_valid_o    = (state_q == StRun);
  assign out_nonce_o    = cur_nonce_q;
  assign out_newblock_o = cur_first_q;
  assign out_last_o     = cur_last_q;
  assign busy_o         = (state_q == StRun) || pend_valid_q;

endmodule

// File: tb/tb_sha_nonce_block_feeder.sv
module tb_sha_nonce_block_feeder;

  typedef struct {
    logic [31:0] w1, w2, w3, base;
    int unsigned k, cnt;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              job_valid = 1'b0;
  logic [31:0]       job_w1 = '0, job_w2 = '0, job_w3 = '0, job_base = '0, job_count = '0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b0;
  logic              jr [2];
  logic              ov [2];
  logic [15:0][31:0] blk [2];
  logic [31:0]       non [2];
  logic              nb [2];
  logic              lst [2];
  logic              bsy [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // dut0: PROCESSORINDEX=0, stride 1; dut1: PROCESSORINDEX=2, stride 4. Shared stimulus.
  sha_nonce_block_feeder #(.PROCESSORINDEX(0), .NUMPROCESSORS(1), .MSG_LEN_BITS(640)) dut0 (
    .clk(clk), .rst(rst), .job_valid_i(job_valid), .job_ready_o(jr[0]),
    .job_w1_i(job_w1), .job_w2_i(job_w2), .job_w3_i(job_w3),
    .job_nonce_base_i(job_base), .job_nonce_count_i(job_count), .abort_i(abort),
    .out_valid_o(ov[0]), .out_ready_i(out_ready), .out_block_o(blk[0]),
    .out_nonce_o(non[0]), .out_newblock_o(nb[0]), .out_last_o(lst[0]), .busy_o(bsy[0])
  );

  sha_nonce_block_feeder #(.PROCESSORINDEX(2), .NUMPROCESSORS(4), .MSG_LEN_BITS(640)) dut1 (
    .clk(clk), .rst(rst), .job_valid_i(job_valid), .job_ready_o(jr[1]),
    .job_w1_i(job_w1), .job_w2_i(job_w2), .job_w3_i(job_w3),
    .job_nonce_base_i(job_base), .job_nonce_count_i(job_count), .abort_i(abort),
    .out_valid_o(ov[1]), .out_ready_i(out_ready), .out_block_o(blk[1]),
    .out_nonce_o(non[1]), .out_newblock_o(nb[1]), .out_last_o(lst[1]), .busy_o(bsy[1])
  );

  // ---------------- reference model ----------------
  function automatic int unsigned pi_of(int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int unsigned np_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [15:0][31:0] ref_block(logic [31:0] w1, w2, w3, n);
    logic [15:0][31:0] b;
    b     = '0;
    b[15] = w1;
    b[14] = w2;
    b[13] = w3;
    b[12] = n;
    b[11] = 32'h8000_0000;
    b[0]  = 32'd640;
    return b;
  endfunction

  // {block, nonce, newblock, last} for beat k of a job as seen by core d.
  function automatic logic [545:0] exp_beat(int d, logic [31:0] w1, w2, w3, base,
                                            int unsigned k, int unsigned cnt);
    logic [31:0] n;
    n = base + pi_of(d) + k * np_of(d);
    return {ref_block(w1, w2, w3, n), n, (k == 0), (k == cnt - 1)};
  endfunction

  function automatic logic [545:0] act_beat(int d);
    return {blk[d], non[d], nb[d], lst[d]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_job(input logic [31:0] w1, w2, w3, base, cnt);
    job_w1    = w1;
    job_w2    = w2;
    job_w3    = w3;
    job_base  = base;
    job_count = cnt;
    job_valid = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ({jr[d], ov[d]} !== 2'b00)
          $display("FAIL reset_hold dut%0d: ready/valid %b want 00", d, {jr[d], ov[d]});
        else n_pass++;
      end
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({jr[d], ov[d], bsy[d], nb[d], lst[d]} !== 5'b10000)
        $display("FAIL reset_flags dut%0d: got %b want 10000", d,
                 {jr[d], ov[d], bsy[d], nb[d], lst[d]});
      else n_pass++;
      n_checks++;
      if ({blk[d], non[d]} !== {ref_block(0, 0, 0, 0), 32'd0})
        $display("FAIL reset_data dut%0d: got %h want %h", d, {blk[d], non[d]},
                 {ref_block(0, 0, 0, 0), 32'd0});
      else n_pass++;
    end
  endtask

  task automatic test_single_job();
    logic [31:0] w1 = $urandom, w2 = $urandom, w3 = $urandom;
    out_ready = 1'b1;
    drive_job(w1, w2, w3, 32'h100, 32'd3);
    step();
    job_valid = 1'b0;
    n_checks++;
    if (ov[0] !== 1'b0) $display("FAIL single_latency1: valid %b want 0", ov[0]);
    else n_pass++;
    step();
    for (int b = 0; b < 3; b++) begin
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (ov[d] !== 1'b1) $display("FAIL single_valid%0d dut%0d: got %b want 1", b, d, ov[d]);
        else n_pass++;
        n_checks++;
        if (act_beat(d) !== exp_beat(d, w1, w2, w3, 32'h100, b, 3))
          $display("FAIL single_beat%0d dut%0d: got %h want %h", b, d, act_beat(d),
                   exp_beat(d, w1, w2, w3, 32'h100, b, 3));
        else n_pass++;
      end
      step();
    end
    n_checks++;
    if ({ov[0], bsy[0]} !== 2'b00) $display("FAIL single_done: got %b want 00", {ov[0], bsy[0]});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] aw1 = $urandom, aw2 = $urandom, aw3 = $urandom, abase = $urandom;
    logic [31:0] bw2 = $urandom, bw3 = $urandom;
    logic        b_acc = 1'b0;
    int          b = 0, cyc = 0;
    logic [545:0] e;
    out_ready = 1'b1;
    drive_job(aw1, aw2, aw3, abase, 32'd2);
    step();
    drive_job(32'hDEAD_BEEF, bw2, bw3, 32'h50, 32'd1);
    while (b < 3 && cyc < 20) begin
      if (b > 0 || ov[0]) begin
        n_checks++;
        if (ov[0] !== 1'b1) $display("FAIL b2b_gap beat%0d: valid %b want 1", b, ov[0]);
        else n_pass++;
      end
      if (ov[0]) begin
        for (int d = 0; d < 2; d++) begin
          e = (b < 2) ? exp_beat(d, aw1, aw2, aw3, abase, b, 2)
                      : exp_beat(d, 32'hDEAD_BEEF, bw2, bw3, 32'h50, 0, 1);
          n_checks++;
          if (act_beat(d) !== e)
            $display("FAIL b2b_beat%0d dut%0d: got %h want %h", b, d, act_beat(d), e);
          else n_pass++;
        end
        b++;
      end
      if (b_acc) job_valid = 1'b0;
      else if (jr[0]) b_acc = 1'b1;
      step();
      cyc++;
    end
    job_valid = 1'b0;
    n_checks++;
    if (b != 3) $display("FAIL b2b_timeout: beats %0d want 3", b);
    else n_pass++;
    n_checks++;
    if ({ov[0], bsy[0]} !== 2'b00) $display("FAIL b2b_done: got %b want 00", {ov[0], bsy[0]});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] w1 = $urandom, w2 = $urandom, w3 = $urandom, base = $urandom;
    int b = 0, stall = 0, cyc = 0;
    out_ready = 1'b1;
    drive_job(w1, w2, w3, base, 32'd6);
    step();
    job_valid = 1'b0;
    while (b < 6 && cyc < 80) begin
      if (ov[0]) begin
        for (int d = 0; d < 2; d++) begin
          n_checks++;
          if (act_beat(d) !== exp_beat(d, w1, w2, w3, base, b, 6))
            $display("FAIL bp_beat%0d_stall%0d dut%0d: got %h want %h", b, stall, d,
                     act_beat(d), exp_beat(d, w1, w2, w3, base, b, 6));
          else n_pass++;
        end
        if (b == 2 && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = (b == 2) || ($urandom_range(0, 3) != 0);
          if (out_ready) b++;
        end
      end
      step();
      cyc++;
    end
    out_ready = 1'b1;
    n_checks++;
    if (b != 6 || stall != 5) $display("FAIL bp_count: beats %0d stalls %0d want 6 5", b, stall);
    else n_pass++;
    n_checks++;
    if ({ov[0], bsy[0]} !== 2'b00) $display("FAIL bp_done: got %b want 00", {ov[0], bsy[0]});
    else n_pass++;
  endtask

  task automatic test_wrap_zero();
    logic [31:0] w1 = $urandom, w2 = $urandom, w3 = $urandom;
    out_ready = 1'b1;
    drive_job(w1, w2, w3, 32'hFFFF_FFFE, 32'd3);
    step();
    job_valid = 1'b0;
    step();
    for (int b = 0; b < 3; b++) begin
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ({ov[d], act_beat(d)} !== {1'b1, exp_beat(d, w1, w2, w3, 32'hFFFF_FFFE, b, 3)})
          $display("FAIL wrap_beat%0d dut%0d: got %h want %h", b, d, {ov[d], act_beat(d)},
                   {1'b1, exp_beat(d, w1, w2, w3, 32'hFFFF_FFFE, b, 3)});
        else n_pass++;
      end
      step();
    end
    drive_job($urandom, $urandom, $urandom, $urandom, 32'd0);
    step();
    job_valid = 1'b0;
    repeat (5) begin
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ({ov[d], bsy[d], jr[d]} !== 3'b001)
          $display("FAIL zero_count dut%0d: valid/busy/ready %b want 001", d,
                   {ov[d], bsy[d], jr[d]});
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_abort();
    logic [31:0] w1 = $urandom, w2 = $urandom, w3 = $urandom, base = $urandom;
    logic b_acc = 1'b0, aborted = 1'b0;
    int   b = 0, cyc = 0;
    out_ready = 1'b1;
    drive_job(w1, w2, w3, base, 32'd5);
    step();
    drive_job($urandom, $urandom, $urandom, $urandom, 32'd3);
    while (!aborted && cyc < 20) begin
      if (ov[0]) begin
        for (int d = 0; d < 2; d++) begin
          n_checks++;
          if (act_beat(d) !== exp_beat(d, w1, w2, w3, base, b, 5))
            $display("FAIL abort_beat%0d dut%0d: got %h want %h", b, d, act_beat(d),
                     exp_beat(d, w1, w2, w3, base, b, 5));
          else n_pass++;
        end
        if (b == 1) abort = 1'b1;
        b++;
      end
      if (b_acc) job_valid = 1'b0;
      else if (jr[0]) b_acc = 1'b1;
      step();
      cyc++;
      if (abort) aborted = 1'b1;
    end
    abort = 1'b0;
    job_valid = 1'b0;
    n_checks++;
    if (!aborted || !b_acc) $display("FAIL abort_setup: aborted %b pending %b want 1 1",
                                     aborted, b_acc);
    else n_pass++;
    repeat (4) begin
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ({ov[d], bsy[d], jr[d]} !== 3'b001)
          $display("FAIL abort_idle dut%0d: valid/busy/ready %b want 001", d,
                   {ov[d], bsy[d], jr[d]});
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] w1 = $urandom, w2 = $urandom, w3 = $urandom, base = $urandom;
    int b = 0, cyc = 0;
    out_ready = 1'b1;
    drive_job(w1, w2, w3, base, 32'd5);
    step();
    job_valid = 1'b0;
    while (b < 2 && cyc < 20) begin
      if (ov[0]) b++;
      if (b < 2) step();
      cyc++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (jr[0] !== 1'b0) $display("FAIL rstmid_ready_now: got %b want 0", jr[0]);
    else n_pass++;
    repeat (2) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ({jr[d], ov[d], bsy[d]} !== 3'b000)
          $display("FAIL rstmid_hold dut%0d: ready/valid/busy %b want 000", d,
                   {jr[d], ov[d], bsy[d]});
        else n_pass++;
      end
    end
    rst = 1'b0;
    repeat (4) begin
      step();
      n_checks++;
      if ({jr[0], ov[0], bsy[0]} !== 3'b100)
        $display("FAIL rstmid_after: ready/valid/busy %b want 100", {jr[0], ov[0], bsy[0]});
      else n_pass++;
    end
  endtask

  task automatic test_random_jobs();
    logic [31:0] jw1 [12], jw2 [12], jw3 [12], jbase [12], jcnt [12];
    beat_t q [$];
    beat_t h;
    int idx = 0, cyc = 0;
    for (int i = 0; i < 12; i++) begin
      jw1[i]   = $urandom;
      jw2[i]   = $urandom;
      jw3[i]   = $urandom;
      jbase[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      jcnt[i]  = $urandom_range(0, 4);
    end
    while (cyc < 3000) begin
      if (idx == 12 && q.size() == 0 && !bsy[0]) break;
      out_ready = ($urandom_range(0, 3) != 0);
      if (ov[0]) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL rand_unexpected: nonce %h with empty model queue", non[0]);
        end else begin
          h = q[0];
          n_pass++;
          for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_beat(d) !== exp_beat(d, h.w1, h.w2, h.w3, h.base, h.k, h.cnt))
              $display("FAIL rand_beat dut%0d: got %h want %h", d, act_beat(d),
                       exp_beat(d, h.w1, h.w2, h.w3, h.base, h.k, h.cnt));
            else n_pass++;
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      job_valid = (idx < 12) && ($urandom_range(0, 2) != 0);
      if (idx < 12) begin
        job_w1    = jw1[idx];
        job_w2    = jw2[idx];
        job_w3    = jw3[idx];
        job_base  = jbase[idx];
        job_count = jcnt[idx];
      end
      if (job_valid && jr[0]) begin
        for (int unsigned k = 0; k < jcnt[idx]; k++) begin
          h.w1   = jw1[idx];
          h.w2   = jw2[idx];
          h.w3   = jw3[idx];
          h.base = jbase[idx];
          h.k    = k;
          h.cnt  = jcnt[idx];
          q.push_back(h);
        end
        idx++;
      end
      step();
      cyc++;
    end
    job_valid = 1'b0;
    n_checks++;
    if (cyc >= 3000) $display("FAIL rand_timeout: jobs %0d beats left %0d", idx, q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_backpressure();
    test_wrap_zero();
    test_abort();
    test_reset_mid_job();
    test_random_jobs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
